// File: rtl/matrix_sweeper.sv
// Sequencer for one matrix product: walks every result cell in row-major order,
// hands each cell to the compute unit, and writes the returned value to the result memory.
module matrix_sweeper #(
  parameter int maxWidthLen = 4,
  parameter int sizeValue   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [maxWidthLen-1:0] width,
  input  logic [maxWidthLen-1:0] height,
  input  logic [maxWidthLen-1:0] limit_in,
  output logic                   cm_start,
  output logic [maxWidthLen-1:0] cm_x,
  output logic [maxWidthLen-1:0] cm_y,
  output logic [maxWidthLen-1:0] cm_limit,
  input  logic                   cm_rdy,
  input  logic [sizeValue-1:0]   cm_out,
  output logic                   wr_en,
  output logic [maxWidthLen-1:0] wr_x,
  output logic [maxWidthLen-1:0] wr_y,
  output logic [sizeValue-1:0]   wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [maxWidthLen-1:0] IDX_ONE = maxWidthLen'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r;
  logic [maxWidthLen-1:0] width_r;
  logic [maxWidthLen-1:0] height_r;
  logic [maxWidthLen-1:0] limit_r;
  logic [maxWidthLen-1:0] x_r;
  logic [maxWidthLen-1:0] y_r;
  logic [maxWidthLen-1:0] wr_x_r;
  logic [maxWidthLen-1:0] wr_y_r;
  logic [sizeValue-1:0]   data_r;
  logic                   cm_start_r;
  logic                   wr_en_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;

  logic zero_s;
  logic x_last_s;
  logic last_s;

  // A zero dimension on the incoming request means there is nothing to sweep.
  assign zero_s   = (width == '0) || (height == '0) || (limit_in == '0);
  assign x_last_s = (x_r == (width_r - IDX_ONE));
  assign last_s   = x_last_s && (y_r == (height_r - IDX_ONE));

  // Sweep FSM; every output flop is loaded alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      width_r    <= '0;
      height_r   <= '0;
      limit_r    <= '0;
      x_r        <= '0;
      y_r        <= '0;
      wr_x_r     <= '0;
      wr_y_r     <= '0;
      data_r     <= '0;
      cm_start_r <= 1'b0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      cm_start_r <= 1'b0;
      wr_en_r    <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            width_r  <= width;
            height_r <= height;
            limit_r  <= limit_in;
            x_r      <= '0;
            y_r      <= '0;
            err_r    <= zero_s;
            busy_r   <= 1'b1;
            if (zero_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= ST_ISSUE;
              cm_start_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready pulse only counts here; stray pulses in other states are dropped.
          if (cm_rdy) begin
            data_r  <= cm_out;
            wr_x_r  <= x_r;
            wr_y_r  <= y_r;
            wr_en_r <= 1'b1;
            state_r <= ST_WRITE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WRITE: begin
          if (x_last_s) begin
            x_r <= '0;
            y_r <= y_r + IDX_ONE;
          end else begin
            x_r <= x_r + IDX_ONE;
          end
          if (last_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r    <= ST_ISSUE;
            cm_start_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cm_start = cm_start_r;
  assign cm_x     = x_r;
  assign cm_y     = y_r;
  assign cm_limit = limit_r;
  assign wr_en    = wr_en_r;
  assign wr_x     = wr_x_r;
  assign wr_y     = wr_y_r;
  assign wr_data  = data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_matrix_sweeper.sv
// Bench for matrix_sweeper: a behavioural cell unit computes fixed-point dot products
// from random matrices; a scoreboard checks write order, data, timing and status.
module tb_matrix_sweeper;
  localparam int MW = 4;
  localparam int SV = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [MW-1:0] width = '0;
  logic [MW-1:0] height = '0;
  logic [MW-1:0] limit_in = '0;
  logic          cm_start;
  logic [MW-1:0] cm_x;
  logic [MW-1:0] cm_y;
  logic [MW-1:0] cm_limit;
  logic          cm_rdy;
  logic [SV-1:0] cm_out = '0;
  logic          wr_en;
  logic [MW-1:0] wr_x;
  logic [MW-1:0] wr_y;
  logic [SV-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  logic model_rdy = 1'b0;
  logic spur_rdy = 1'b0;
  assign cm_rdy = model_rdy | spur_rdy;

  int checks = 0;
  int failures = 0;

  logic signed [SV-1:0] ma [16][16];
  logic signed [SV-1:0] mb [16][16];
  int got_x[$];
  int got_y[$];
  logic [SV-1:0] got_d[$];

  matrix_sweeper #(.maxWidthLen(MW), .sizeValue(SV)) dut (
    .clk(clk), .rst(rst), .go(go), .width(width), .height(height), .limit_in(limit_in),
    .cm_start(cm_start), .cm_x(cm_x), .cm_y(cm_y), .cm_limit(cm_limit),
    .cm_rdy(cm_rdy), .cm_out(cm_out), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Result cell (x,y) of A*B over inner dimension l, in signed fixed point.
  function automatic logic [SV-1:0] cell_val(input int x, input int y, input int l);
    longint acc;
    acc = 0;
    for (int k = 0; k < l; k++) acc += longint'(ma[y][k]) * longint'(mb[k][x]);
    return SV'(acc >>> (SV / 2));
  endfunction

  // Cell unit model: result valid 5L+1 cycles after its start pulse, garbage data otherwise.
  int cell_cnt = 0;
  logic [SV-1:0] cell_res = '0;
  always @(posedge clk) begin
    #1;
    model_rdy = 1'b0;
    cm_out = SV'($urandom);
    if (!rst) begin
      cell_cnt = 0;
    end else if (cell_cnt > 0) begin
      cell_cnt--;
      if (cell_cnt == 0) begin
        model_rdy = 1'b1;
        cm_out = cell_res;
      end
    end else if (cm_start) begin
      cell_cnt = 5 * int'(cm_limit) + 1;
      cell_res = cell_val(int'(cm_x), int'(cm_y), int'(cm_limit));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        ma[r][c] = SV'($urandom_range(0, 16'h03FF)) - SV'(16'h0200);
        mb[r][c] = SV'($urandom_range(0, 16'h03FF)) - SV'(16'h0200);
      end
  endtask

  // Runs one job from go to the cycle after done, checking every start and write.
  task automatic run_job(input int w, input int h, input int l, input bit inject);
    int n, nw, starts, done_n, ncell, per;
    bit zero;
    int ex_x[$];
    int ex_y[$];
    logic [SV-1:0] ex_d[$];
    zero = (w == 0) || (h == 0) || (l == 0);
    ncell = zero ? 0 : w * h;
    per = 5 * l + 3;
    got_x.delete(); got_y.delete(); got_d.delete();
    for (int y = 0; y < h && !zero; y++)
      for (int x = 0; x < w; x++) begin
        ex_x.push_back(x); ex_y.push_back(y); ex_d.push_back(cell_val(x, y, l));
      end
    @(negedge clk);
    width = MW'(w); height = MW'(h); limit_in = MW'(l); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 1; nw = 0; starts = 0; done_n = 0;
    while (done_n == 0 && n < 3000) begin
      if (cm_start) begin
        if (starts < ex_x.size())
          chk("cm_coord", 64'({cm_y, cm_x, cm_limit}),
              64'({MW'(ex_y[starts]), MW'(ex_x[starts]), MW'(l)}));
        else
          chk("start_count", 64'(starts + 1), 64'(ex_x.size()));
        if (inject && starts == 1) spur_rdy = 1'b1;
        starts++;
      end
      if (wr_en) begin
        if (nw < ex_x.size()) begin
          chk("write", 64'({wr_y, wr_x, wr_data}),
              64'({MW'(ex_y[nw]), MW'(ex_x[nw]), ex_d[nw]}));
          chk("write_cycle", 64'(n), 64'((nw + 1) * per));
        end else begin
          chk("write_count", 64'(nw + 1), 64'(ex_x.size()));
        end
        got_x.push_back(int'(wr_x)); got_y.push_back(int'(wr_y)); got_d.push_back(wr_data);
        nw++;
      end
      if (inject && n == 10) begin
        go = 1'b1; width = MW'($urandom_range(1, 15)); limit_in = MW'($urandom_range(1, 15));
      end
      if (inject && n == 11) go = 1'b0;
      if (done) begin
        done_n = n;
        chk("err_at_done", 64'(err), 64'(zero));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
      @(negedge clk);
      spur_rdy = 1'b0;
      n++;
    end
    chk("done_cycle", 64'(done_n), 64'(ncell * per + 1));
    chk("write_total", 64'(nw), 64'(ncell));
    chk("start_total", 64'(starts), 64'(ncell));
    chk("after_done", 64'({busy, done, err}), 64'({1'b0, 1'b0, zero}));
  endtask

  initial begin
    int n, starts, nw, idle_bad;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({cm_start, cm_x, cm_y, cm_limit, wr_en, wr_x, wr_y, wr_data, busy, done, err}), 64'd0);
    rst = 1'b1;

    // Identity times B: values must come through exactly.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    ma[0][0] = 16'sh0100; ma[1][1] = 16'sh0100;
    mb[0][0] = 16'sh0200; mb[0][1] = 16'sh0080; mb[1][0] = -16'sh0100; mb[1][1] = 16'sh0300;
    run_job(2, 2, 2, 1'b0);
    chk("ident_00", 64'({MW'(got_x[0]), MW'(got_y[0]), got_d[0]}), 64'({4'd0, 4'd0, 16'h0200}));
    chk("ident_10", 64'({MW'(got_x[1]), MW'(got_y[1]), got_d[1]}), 64'({4'd1, 4'd0, 16'h0080}));
    chk("ident_01", 64'({MW'(got_x[2]), MW'(got_y[2]), got_d[2]}), 64'({4'd0, 4'd1, 16'hFF00}));
    chk("ident_11", 64'({MW'(got_x[3]), MW'(got_y[3]), got_d[3]}), 64'({4'd1, 4'd1, 16'h0300}));

    // Mid-sweep go and a stray ready during ISSUE must change nothing.
    run_job(2, 2, 2, 1'b1);

    // 1x1 with inner dimension 3, all ones.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin ma[r][c] = 16'sh0100; mb[r][c] = 16'sh0100; end
    run_job(1, 1, 3, 1'b0);
    chk("one_by_one", 64'(got_d[0]), 64'(16'h0300));

    // Zero dimension errors out immediately; a valid job afterwards clears err.
    run_job(0, 2, 2, 1'b0);
    run_job(1, 1, 1, 1'b0);

    // Reset during WAIT of cell (1,0).
    fill_random();
    @(negedge clk);
    width = 4'd2; height = 4'd2; limit_in = 4'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 1; starts = 0; nw = 0;
    while (starts < 2 && n < 200) begin
      if (cm_start) starts++;
      if (wr_en) nw++;
      @(negedge clk);
      n++;
    end
    chk("pre_rst_starts", 64'(starts), 64'd2);
    repeat (2) begin
      if (wr_en) nw++;
      @(negedge clk);
    end
    chk("pre_rst_writes", 64'(nw), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", 64'({cm_start, cm_x, cm_y, cm_limit, wr_en, wr_x, wr_y, wr_data, busy, done, err}), 64'd0);
    rst = 1'b1;
    spur_rdy = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      spur_rdy = 1'b0;
      if (wr_en || busy || cm_start) idle_bad++;
    end
    chk("post_rst_idle", 64'(idle_bad), 64'd0);
    run_job(2, 2, 2, 1'b0);

    // Non-square sweep, period 8.
    fill_random();
    run_job(3, 2, 1, 1'b0);

    // Random jobs.
    for (int j = 0; j < 4; j++) begin
      fill_random();
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
